// File: rtl/mips_reg_file_pkg.sv
// Shared constants and the write-address decoder for the MIPS register file.
// Latency: none (package only).
// Backpressure: none (package only).
package mips_reg_file_pkg;

    localparam int NUM_REGS         = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int REG_ZERO         = 0;
    localparam int REG_SP           = 29;
    localparam int SP_RESET_DEFAULT = 252;

    // Decode a register index into one-hot write enables for the storage entries.
    // Entry 0 has no storage, so its enable bit is simply not produced and a
    // write to index 0 selects nothing.
    function automatic logic [NUM_REGS-1:1] decode_onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [NUM_REGS-1:1] dec;
        dec = '0;
        for (int k = 1; k < NUM_REGS; k++) begin
            dec[k] = (idx == REG_ADDR_W'(k));
        end
        return dec;
    endfunction

endpackage

// File: rtl/mips_reg_file_en_reg.sv
// Enabled register with synchronous clear-to-INIT; one storage entry of the file.
// Latency: q_o reflects d_i one cycle after an enabled edge.
// Backpressure: none; reset wins over enable.
module rf_en_reg #(
    parameter int             W    = 32,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Hold unless enabled.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    // State register; reset takes priority over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mips_reg_file.sv
// 32 x N register file: one synchronous write port, two combinational read ports.
// Latency: writes visible right after the edge; reads are zero-cycle, no bypass.
// Backpressure: none; every write is accepted, reset discards a coincident write.
module mips_reg_file
    import mips_reg_file_pkg::*;
#(
    parameter int N        = 32,
    parameter int SP_RESET = SP_RESET_DEFAULT   // byte address, keep word aligned
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Reg_Write_i,
    input  logic [REG_ADDR_W-1:0] Write_Register_i,
    input  logic [N-1:0]          Write_Data_i,
    input  logic [REG_ADDR_W-1:0] Read_Register_1_i,
    input  logic [REG_ADDR_W-1:0] Read_Register_2_i,
    output logic [N-1:0]          Read_Data_1_o,
    output logic [N-1:0]          Read_Data_2_o
);

    logic [NUM_REGS-1:1]         wr_en;
    logic [NUM_REGS-1:0][N-1:0]  reg_val;

    // Gate the decoded write address with the write enable.
    always_comb begin
        wr_en = '0;
        if (Reg_Write_i) begin
            wr_en = decode_onehot(Write_Register_i);
        end
    end

    // Register 0 is a constant, not storage.
    assign reg_val[REG_ZERO] = '0;

    genvar k;
    generate
        for (k = 1; k < NUM_REGS; k++) begin : g_regs
            localparam logic [N-1:0] INIT_VAL = (k == REG_SP) ? N'(SP_RESET) : '0;
            rf_en_reg #(
                .W    (N),
                .INIT (INIT_VAL)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .en_i  (wr_en[k]),
                .d_i   (Write_Data_i),
                .q_o   (reg_val[k])
            );
        end
    endgenerate

    // Two independent 32:1 read muxes; no forwarding of the in-flight write.
    always_comb begin
        Read_Data_1_o = reg_val[Read_Register_1_i];
        Read_Data_2_o = reg_val[Read_Register_2_i];
    end

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file with directed scenarios and random traffic.
// Latency: reads checked combinationally; writes checked one edge later.
// Backpressure: none.
module tb_mips_reg_file;

    localparam int N  = 32;
    localparam int SP = 252;

    logic          clk;
    logic          reset;
    logic          Reg_Write_i;
    logic [4:0]    Write_Register_i;
    logic [N-1:0]  Write_Data_i;
    logic [4:0]    Read_Register_1_i;
    logic [4:0]    Read_Register_2_i;
    logic [N-1:0]  Read_Data_1_o;
    logic [N-1:0]  Read_Data_2_o;

    int n_cmp;
    int n_err;

    // Reference: architectural contents of R0..R31.
    logic [N-1:0] model [32];

    mips_reg_file #(.N(N), .SP_RESET(SP)) dut (
        .clk               (clk),
        .reset             (reset),
        .Reg_Write_i       (Reg_Write_i),
        .Write_Register_i  (Write_Register_i),
        .Write_Data_i      (Write_Data_i),
        .Read_Register_1_i (Read_Register_1_i),
        .Read_Register_2_i (Read_Register_2_i),
        .Read_Data_1_o     (Read_Data_1_o),
        .Read_Data_2_o     (Read_Data_2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the current inputs to the model, then let the DUT see one rising edge.
    task automatic step();
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
            model[29] = N'(SP);
        end else if (Reg_Write_i && Write_Register_i != 5'd0) begin
            model[Write_Register_i] = Write_Data_i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset       = 1'b0;
        Reg_Write_i = 1'b0;
        Write_Register_i = '0;
        Write_Data_i     = '0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [N-1:0] d);
        Reg_Write_i = 1'b1;
        Write_Register_i = a;
        Write_Data_i = d;
        step();
        Reg_Write_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [N-1:0] exp;
            exp = (i == 29) ? 32'h0000_00FC : 32'h0;
            Read_Register_1_i = 5'(i);
            Read_Register_2_i = 5'(31 - i);
            #1;
            n_cmp++;
            if (Read_Data_1_o !== exp) begin
                n_err++;
                $display("FAIL reset_rs idx=%0d got=%h exp=%h", i, Read_Data_1_o, exp);
            end
            exp = ((31 - i) == 29) ? 32'h0000_00FC : 32'h0;
            n_cmp++;
            if (Read_Data_2_o !== exp) begin
                n_err++;
                $display("FAIL reset_rt idx=%0d got=%h exp=%h", 31 - i, Read_Data_2_o, exp);
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            Read_Register_1_i = 5'(i);
            #1;
            n_cmp++;
            if (Read_Data_1_o !== model[i]) begin
                n_err++;
                $display("FAIL %s idx=%0d got=%h exp=%h", tag, i, Read_Data_1_o, model[i]);
            end
        end
    endtask

    task automatic test_write_readback();
        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        Read_Register_1_i = 5'd5;
        Read_Register_2_i = 5'd31;
        #1;
        n_cmp++;
        if (Read_Data_1_o !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr_r5 got=%h exp=%h", Read_Data_1_o, 32'hDEADBEEF);
        end
        n_cmp++;
        if (Read_Data_2_o !== 32'h12345678) begin
            n_err++;
            $display("FAIL wr_r31 got=%h exp=%h", Read_Data_2_o, 32'h12345678);
        end
        check_all("wr_others");
    endtask

    task automatic test_zero_reg();
        do_write(5'd0, 32'hFFFFFFFF);
        Read_Register_1_i = 5'd0;
        Read_Register_2_i = 5'd0;
        #1;
        n_cmp++;
        if (Read_Data_1_o !== 32'h0 || Read_Data_2_o !== 32'h0) begin
            n_err++;
            $display("FAIL zero_reg rs=%h rt=%h exp=0", Read_Data_1_o, Read_Data_2_o);
        end
    endtask

    task automatic test_write_disable();
        do_write(5'd7, 32'h0000_1234);
        Reg_Write_i = 1'b0;
        Write_Register_i = 5'd7;
        Write_Data_i = 32'hAAAA5555;
        step();
        Read_Register_2_i = 5'd7;
        #1;
        n_cmp++;
        if (Read_Data_2_o !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL we_low_r7 got=%h exp=%h", Read_Data_2_o, 32'h0000_1234);
        end
    endtask

    task automatic test_same_cycle();
        do_write(5'd9, 32'h11);
        Read_Register_1_i = 5'd9;
        Reg_Write_i = 1'b1;
        Write_Register_i = 5'd9;
        Write_Data_i = 32'h22;
        #1;
        n_cmp++;
        if (Read_Data_1_o !== 32'h11) begin
            n_err++;
            $display("FAIL same_cycle_before got=%h exp=%h", Read_Data_1_o, 32'h11);
        end
        step();
        Reg_Write_i = 1'b0;
        n_cmp++;
        if (Read_Data_1_o !== 32'h22) begin
            n_err++;
            $display("FAIL same_cycle_after got=%h exp=%h", Read_Data_1_o, 32'h22);
        end
    endtask

    task automatic test_reset_priority();
        do_write(5'd29, 32'h55);
        do_write(5'd3, 32'h99);
        Read_Register_1_i = 5'd29;
        #1;
        n_cmp++;
        if (Read_Data_1_o !== 32'h55) begin
            n_err++;
            $display("FAIL rst_prio_pre got=%h exp=%h", Read_Data_1_o, 32'h55);
        end
        reset = 1'b1;
        Reg_Write_i = 1'b1;
        Write_Register_i = 5'd3;
        Write_Data_i = 32'h77;
        step();
        reset = 1'b0;
        Reg_Write_i = 1'b0;
        Read_Register_1_i = 5'd29;
        Read_Register_2_i = 5'd3;
        #1;
        n_cmp++;
        if (Read_Data_1_o !== 32'd252) begin
            n_err++;
            $display("FAIL rst_prio_r29 got=%h exp=%h", Read_Data_1_o, 32'd252);
        end
        n_cmp++;
        if (Read_Data_2_o !== 32'h0) begin
            n_err++;
            $display("FAIL rst_prio_r3 got=%h exp=0", Read_Data_2_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset            = ($urandom_range(0, 29) == 0);
            Reg_Write_i      = 1'($urandom_range(0, 1));
            Write_Register_i = 5'($urandom_range(0, 31));
            Write_Data_i     = $urandom;
            Read_Register_1_i = 5'($urandom_range(0, 31));
            Read_Register_2_i = ($urandom_range(0, 3) == 0) ? Write_Register_i
                                                            : 5'($urandom_range(0, 31));
            #1;
            n_cmp++;
            if (Read_Data_1_o !== model[Read_Register_1_i]) begin
                n_err++;
                $display("FAIL rand_rs cyc=%0d idx=%0d got=%h exp=%h", c,
                         Read_Register_1_i, Read_Data_1_o, model[Read_Register_1_i]);
            end
            n_cmp++;
            if (Read_Data_2_o !== model[Read_Register_2_i]) begin
                n_err++;
                $display("FAIL rand_rt cyc=%0d idx=%0d got=%h exp=%h", c,
                         Read_Register_2_i, Read_Data_2_o, model[Read_Register_2_i]);
            end
            step();
        end
        idle_inputs();
        check_all("rand_final");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        idle_inputs();
        Read_Register_1_i = '0;
        Read_Register_2_i = '0;
        @(negedge clk);

        test_reset();
        test_write_readback();
        test_zero_reg();
        test_write_disable();
        test_same_cycle();
        test_reset_priority();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
